// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: valid/ready handshake with a one-entry skid
// buffer, synchronous flush and a saturating stall counter.
module if_id_pipe #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic in_fire;
  logic out_fire;

  // Both ready/valid outputs decode straight from the state register.
  always_comb begin
    in_ready  = (state_q != S_SKID);
    out_valid = (state_q != S_EMPTY);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Decode-side data: NOP when empty; PC holds last main value when empty.
  always_comb begin
    out_instr   = (state_q == S_EMPTY) ? NOP_INSTR : main_instr_q;
    out_pc      = main_pc_q;
    stall_count = stall_q;
  end

  // Next state and storage loads; flush overrides every transition.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d      = S_FULL;
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end
      end
      S_FULL: begin
        if (in_fire && out_fire) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end else if (in_fire) begin
          state_d      = S_SKID;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (out_fire) begin
          state_d      = S_FULL;
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Dropping back to EMPTY without loading main keeps out_pc stable.
    if (flush) begin
      state_d      = S_EMPTY;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
    end
  end

  // Saturating count of cycles where decode is back-pressuring a valid beat.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State, storage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Testbench for if_id_pipe: queue-based reference model and scoreboard.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flush;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] out_instr, out_pc, out_instr4, out_pc4;
  logic [15:0] stall16;
  logic [3:0]  stall4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t       sb[$];
  int unsigned n_stall   = 0;
  logic [31:0] last_pc   = '0;
  int unsigned acc_cnt   = 0;
  int unsigned delivered = 0;
  int unsigned nerr      = 0;
  int unsigned nchecks   = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .flush(flush), .stall_count(stall16)
  );

  if_id_pipe #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid4),
    .out_ready(out_ready), .out_instr(out_instr4), .out_pc(out_pc4),
    .flush(flush), .stall_count(stall4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the model, then advance the model by the
  // inputs that will be sampled at the coming edge.
  always @(negedge clk) begin
    logic        can_acc;
    logic [31:0] e_instr, e_pc;
    e_instr = (sb.size() > 0) ? sb[0].instr : NOP;
    e_pc    = (sb.size() > 0) ? sb[0].pc : last_pc;
    check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
    check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    check("out_instr", 64'(out_instr), 64'(e_instr));
    check("out_pc", 64'(out_pc), 64'(e_pc));
    check("stall16", 64'(stall16), 64'((n_stall > 65535) ? 65535 : n_stall));
    check("stall4", 64'(stall4), 64'((n_stall > 15) ? 15 : n_stall));
    check("out_valid_w4", 64'(out_valid4), 64'(sb.size() > 0));
    check("out_instr_w4", 64'(out_instr4), 64'(e_instr));
    if (out_valid && out_ready && sb.size() == 0) begin
      check("spurious_beat", 64'(out_valid), 64'(0));
    end
    if (reset) begin
      sb.delete();
      n_stall = 0;
      last_pc = '0;
    end else begin
      if (sb.size() > 0 && !out_ready) n_stall++;
      can_acc = (sb.size() < 2);
      if (sb.size() > 0 && out_ready) begin
        void'(sb.pop_front());
        delivered++;
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && can_acc) begin
        sb.push_back('{instr: in_instr, pc: in_pc});
        acc_cnt++;
      end
      if (sb.size() > 0) last_pc = sb[0].pc;
    end
  end

  // Drive one cycle of inputs, then wait until just after the next edge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic rst);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic ordy);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned idx, prev, budget;
    logic [31:0] ins;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // First beat straight through
    cyc(1'b1, 32'h00A0_0093, 32'h100, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Stream 16 beats with random back-pressure
    delivered = 0;
    idx = 0;
    budget = 0;
    ins = $urandom;
    while (idx < 16 && budget < 400) begin
      prev = acc_cnt;
      cyc(1'b1, ins, 32'(idx * 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (acc_cnt != prev) begin
        idx++;
        ins = $urandom;
      end
      budget++;
    end
    check("stream_accepts", 64'(idx), 64'd16);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      idle(1, 1'b1);
      budget++;
    end
    check("stream_delivered", 64'(delivered), 64'd16);

    // Fill to SKID and stall 5 cycles, then release
    cyc(1'b1, 32'h11, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 32'h204, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    check("skid_held", 64'(out_instr), 64'h11);
    idle(3, 1'b1);

    // Flush while in SKID with a beat on the input
    cyc(1'b1, 32'h11, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 32'h204, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 32'h208, 1'b0, 1'b1, 1'b0);
    check("flush_nop", 64'(out_instr), 64'(NOP));
    idle(3, 1'b1);

    // Counter saturation from a clean count, then flush must keep it
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h77, 32'h300, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    check("sat4", 64'(stall4), 64'd15);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset with flush while in SKID
    cyc(1'b1, 32'h44, 32'h400, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 32'h404, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("rst_out_pc", 64'(out_pc), 64'h0);
    idle(2, 1'b1);

    // Random traffic with occasional flush
    for (int unsigned i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), 1'b0);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer, a synchronous flush and a saturating stall counter. It sits between instruction fetch and decode. It carries the instruction word and its PC so that fetch can keep issuing while decode back-pressures. No beat is lost or duplicated, and both ready outputs are registered.

## Interface
- `INSTR_W`, default 32, instruction word width.
- `PC_W`, default 32, program-counter width.
- `NOP_INSTR`, default 32'h0000_0000 (`INSTR_W` bits), word driven on `out_instr` whenever the stage is empty.
- `CNT_W`, default 16, stall-counter width.

- `clk`, input, 1, single clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high.
- `in_valid`, input, 1, fetch presents a beat.
- `in_ready`, output, 1, stage accepts a beat; decoded from state only.
- `in_instr`, input, `INSTR_W`, fetched instruction.
- `in_pc`, input, `PC_W`, PC of `in_instr`.
- `out_valid`, output, 1, decode-side beat valid.
- `out_ready`, input, 1, decode accepts the beat.
- `out_instr`, output, `INSTR_W`, instruction to decode.
- `out_pc`, output, `PC_W`, PC to decode.
- `flush`, input, 1, discard all held and incoming beats (branch/jump redirect).
- `stall_count`, output, `CNT_W`, number of cycles with `out_valid & !out_ready`; saturates.

## Operation
- Storage consists of a main register (instr, pc) feeding the outputs and a skid register (instr, pc).
- Handshake events:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- State machine:
  - EMPTY (`out_valid`=0, `in_ready`=1)
  - FULL (`out_valid`=1, `in_ready`=1)
  - SKID (`out_valid`=1, `in_ready`=0)
- Transitions from EMPTY:
  - `in_fire` -> FULL; main <= in.
  - Otherwise stay in EMPTY.
- Transitions from FULL:
  - `in_fire & out_fire` -> FULL; main <= in.
  - `in_fire & !out_fire` -> SKID; skid <= in.
  - `!in_fire & out_fire` -> EMPTY.
  - Otherwise hold.
- Transitions from SKID:
  - `out_fire` -> FULL; main <= skid.
  - Otherwise hold.
  - `in_valid` is ignored in SKID.
- Outputs:
  - `out_instr` = NOP_INSTR in EMPTY, otherwise main instr.
  - `out_pc` = main pc in FULL and SKID.
  - `out_pc` holds its last value in EMPTY; it is don't-care there, but the bench checks that it is stable.
- Ordering: beats leave in exactly the order they were accepted. Order is main first, then skid.
- Flush:
  - Next state is EMPTY and the skid is discarded.
  - Any `in_fire` in the same cycle is dropped; flush has priority over every transition.
  - An `out_fire` in the flush cycle still counts as consumed by decode.
- Stall counter:
  - Increments by 1 on every cycle with `out_valid & !out_ready`, including the flush cycle.
  - Saturates at 2^`CNT_W`-1; there is no wrap.
  - Only `reset` clears it; `flush` does not.
- Reset values:
  - State EMPTY, so `out_valid`=0 and `in_ready`=1.
  - `out_instr`=NOP_INSTR, `out_pc`=0.
  - Main and skid registers are 0.
  - `stall_count`=0.
  - Reset overrides flush and all handshakes.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N when the stage was EMPTY or FULL-and-draining.
- Throughput: 1 beat/cycle in steady state when `out_ready`=1.
- `in_ready` falls one cycle after the first stalled accept and rises one cycle after the draining `out_fire`.
- There is no combinational path from `out_ready` to `in_ready`. The only combinational path from an input to an output is state -> `out_instr` mux.
- `out_valid` never drops without an `out_fire`, flush or reset. `out_instr`/`out_pc` are stable while `out_valid & !out_ready`.
- Reset asserted mid-operation: the next edge gives EMPTY, any held beats are lost, and `stall_count`=0.

## Test plan
- Reset, then `in_valid`=1 with 0x00A00093 at pc 0x100 and `out_ready`=1 -> the next cycle shows `out_valid`=1, `out_instr`=0x00A00093, `out_pc`=0x100, and `in_ready` stays 1.
- Stream pcs 0x0,0x4,...,0x3C with `out_ready` toggling randomly -> decode receives all 16 beats in order with no duplicates; `in_ready`=0 only in SKID; `stall_count` equals the number of stalled-valid cycles.
- Fill to SKID with 0x11 and 0x22, hold `out_ready`=0 for 5 cycles -> outputs stay 0x11; `stall_count` +5; `in_ready`=0; releasing gives 0x11 then 0x22.
- Assert `flush` in SKID together with `in_valid`=1 carrying 0x33 -> the next cycle is EMPTY with `out_instr`=NOP_INSTR and `in_ready`=1; 0x33 never appears at the output.
- `CNT_W`=4 with `out_ready` held at 0 for 20 cycles while FULL -> `stall_count` saturates at 15.
- Assert `reset` while in SKID with `flush`=1 -> the next cycle shows `out_valid`=0, `in_ready`=1, `stall_count`=0, `out_pc`=0.
